// File: rtl/regfile_mp_pkg.sv
// Shared constants, write-source encoding and helpers for the multi-port register file.
// Build option: define RF_BYPASS_EN to forward same-cycle writes to the read ports.
package rf_pkg;

  localparam int LINK_REG_DEF = 31;
  localparam int ZERO_REG     = 0;

  // Encoding value doubles as write priority rank: wb > wa > link.
  typedef enum logic [1:0] {
    WS_NONE = 2'd0,
    WS_LINK = 2'd1,
    WS_A    = 2'd2,
    WS_B    = 2'd3
  } wsrc_e;

  function automatic int rf_aw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic wsrc_e wr_pick(input logic b, input logic a, input logic l);
    if (b) return WS_B;
    if (a) return WS_A;
    if (l) return WS_LINK;
    return WS_NONE;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One register-file read port: storage mux, optional same-cycle write forwarding, busy qualify.
// Forwarding is selected by the BYPASS parameter, which the top drives from RF_BYPASS_EN.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int DW       = 32,
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int LINK_REG = LINK_REG_DEF,
  parameter bit BYPASS   = 1'b0
) (
  input  logic [AW-1:0]            addr,
  input  logic [NREG-1:0][DW-1:0]  regs,
  input  logic [NREG-1:0]          pending,
  input  logic                     wa_en,
  input  logic [AW-1:0]            wa_addr,
  input  logic [DW-1:0]            wa_data,
  input  logic                     wb_en,
  input  logic [AW-1:0]            wb_addr,
  input  logic [DW-1:0]            wb_data,
  input  logic                     link_en,
  input  logic [DW-1:0]            link_data,
  output logic [DW-1:0]            data,
  output logic                     busy
);

  localparam logic [AW-1:0] LINK_A = AW'(LINK_REG);
  localparam logic [AW-1:0] ZERO_A = AW'(ZERO_REG);

  always_comb begin
    data = regs[addr];
    busy = pending[addr];
    if (BYPASS) begin
      // Applied lowest priority first so the later, higher-priority source overrides.
      if (link_en && addr == LINK_A) data = link_data;
      if (wa_en && addr == wa_addr) begin
        data = wa_data;
        busy = 1'b0;
      end
      if (wb_en && addr == wb_addr) begin
        data = wb_data;
        busy = 1'b0;
      end
    end
    if (addr == ZERO_A) begin
      data = '0;
      busy = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD read ports, two writeback ports, link write and pending scoreboard.
// Build option: define RF_BYPASS_EN to forward same-cycle writes to rd_data/rd_busy.
module regfile_mp
  import rf_pkg::*;
#(
  parameter  int DW       = 32,
  parameter  int NREG     = 32,
  parameter  int NRD      = 2,
  parameter  int LINK_REG = LINK_REG_DEF,
  localparam int AW       = rf_aw(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*DW-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              wa_en,
  input  logic [AW-1:0]     wa_addr,
  input  logic [DW-1:0]     wa_data,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DW-1:0]     wb_data,
  input  logic              link_en,
  input  logic [DW-1:0]     link_data,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DW-1:0]     dbg_data
);

`ifdef RF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  localparam logic [AW-1:0] LINK_A = AW'(LINK_REG);

  logic [NREG-1:0][DW-1:0] regs;
  logic [NREG-1:0]         pending;
  logic [NREG-1:0]         set_p;
  wsrc_e                   src [NREG];

  // Everything presented during reset is dropped, including what bypass would forward.
  logic wa_go, wb_go, link_go, iss_go;
  assign wa_go   = wa_en   & ~rst;
  assign wb_go   = wb_en   & ~rst;
  assign link_go = link_en & ~rst;
  assign iss_go  = iss_en  & ~rst;

  always_comb begin
    src[0]   = WS_NONE;
    set_p[0] = 1'b0;
    for (int r = 1; r < NREG; r++) begin
      src[r]   = wr_pick(wb_go && wb_addr == AW'(r),
                         wa_go && wa_addr == AW'(r),
                         link_go && LINK_A == AW'(r));
      set_p[r] = iss_go && iss_addr == AW'(r);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs    <= '0;
      pending <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        case (src[r])
          WS_B:    regs[r] <= wb_data;
          WS_A:    regs[r] <= wa_data;
          WS_LINK: regs[r] <= link_data;
          default: ;
        endcase
        // A new issue outranks a retiring producer on the same register.
        if (set_p[r])                             pending[r] <= 1'b1;
        else if (src[r] == WS_A || src[r] == WS_B) pending[r] <= 1'b0;
      end
    end
  end

  assign dbg_data = regs[dbg_addr];

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    rf_read_port #(
      .DW(DW), .NREG(NREG), .AW(AW), .LINK_REG(LINK_REG), .BYPASS(BYPASS)
    ) u_rd (
      .addr     (rd_addr[i*AW +: AW]),
      .regs     (regs),
      .pending  (pending),
      .wa_en    (wa_go),
      .wa_addr  (wa_addr),
      .wa_data  (wa_data),
      .wb_en    (wb_go),
      .wb_addr  (wb_addr),
      .wb_data  (wb_data),
      .link_en  (link_go),
      .link_data(link_data),
      .data     (rd_data[i*DW +: DW]),
      .busy     (rd_busy[i])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: default 32x32/2-port instance plus a 16x16/4-port instance.
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit, 32-register, 2-read-port instance
  logic        rst0;
  logic [9:0]  rd_addr0;
  logic [63:0] rd_data0;
  logic [1:0]  rd_busy0;
  logic        wa_en0, wb_en0, link_en0, iss_en0;
  logic [4:0]  wa_addr0, wb_addr0, iss_addr0, dbg_addr0;
  logic [31:0] wa_data0, wb_data0, link_data0, dbg_data0;

  // 16-bit, 16-register, 4-read-port instance
  logic        rst1;
  logic [15:0] rd_addr1;
  logic [63:0] rd_data1;
  logic [3:0]  rd_busy1;
  logic        wa_en1, wb_en1, link_en1, iss_en1;
  logic [3:0]  wa_addr1, wb_addr1, iss_addr1, dbg_addr1;
  logic [15:0] wa_data1, wb_data1, link_data1, dbg_data1;

  regfile_mp #(.DW(32), .NREG(32), .NRD(2), .LINK_REG(31)) dut0 (
    .clk(clk), .rst(rst0), .rd_addr(rd_addr0), .rd_data(rd_data0), .rd_busy(rd_busy0),
    .wa_en(wa_en0), .wa_addr(wa_addr0), .wa_data(wa_data0),
    .wb_en(wb_en0), .wb_addr(wb_addr0), .wb_data(wb_data0),
    .link_en(link_en0), .link_data(link_data0),
    .iss_en(iss_en0), .iss_addr(iss_addr0),
    .dbg_addr(dbg_addr0), .dbg_data(dbg_data0)
  );

  regfile_mp #(.DW(16), .NREG(16), .NRD(4), .LINK_REG(15)) dut1 (
    .clk(clk), .rst(rst1), .rd_addr(rd_addr1), .rd_data(rd_data1), .rd_busy(rd_busy1),
    .wa_en(wa_en1), .wa_addr(wa_addr1), .wa_data(wa_data1),
    .wb_en(wb_en1), .wb_addr(wb_addr1), .wb_data(wb_data1),
    .link_en(link_en1), .link_data(link_data1),
    .iss_en(iss_en1), .iss_addr(iss_addr1),
    .dbg_addr(dbg_addr1), .dbg_data(dbg_data1)
  );

  // kind: 0 = rd_data, 1 = rd_busy, 2 = dbg_data
  typedef struct {
    int          dut;
    int          kind;
    int          port;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // Monitor: drains every expectation queued for the current cycle at the falling edge.
  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [31:0] act;
    while (q.size() > 0) begin
      e = q.pop_front();
      act = '0;
      if (e.dut == 0) begin
        case (e.kind)
          0:       act = rd_data0[e.port*32 +: 32];
          1:       act = {31'b0, rd_busy0[e.port]};
          default: act = dbg_data0;
        endcase
      end else begin
        case (e.kind)
          0:       act = {16'b0, rd_data1[e.port*16 +: 16]};
          1:       act = {31'b0, rd_busy1[e.port]};
          default: act = {16'b0, dbg_data1};
        endcase
      end
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL %s dut%0d kind%0d port%0d got=%h expected=%h",
                 e.name, e.dut, e.kind, e.port, act, e.exp);
      end
    end
  end

  initial begin : watchdog
    #100000;
    failures++;
    $display("FAIL timeout: stimulus did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic push(input int dut, input int kind, input int port,
                      input logic [31:0] v, input string n);
    exp_t e;
    e.dut = dut; e.kind = kind; e.port = port; e.exp = v; e.name = n;
    q.push_back(e);
  endtask

  task automatic rd0(input int p, input logic [4:0] a, input logic [31:0] d,
                     input logic b, input string n);
    rd_addr0[p*5 +: 5] = a;
    push(0, 0, p, d, n);
    push(0, 1, p, {31'b0, b}, n);
  endtask

  task automatic dbg0(input logic [4:0] a, input logic [31:0] d, input string n);
    dbg_addr0 = a;
    push(0, 2, 0, d, n);
  endtask

  task automatic rd1(input int p, input logic [3:0] a, input logic [15:0] d,
                     input logic b, input string n);
    rd_addr1[p*4 +: 4] = a;
    push(1, 0, p, {16'b0, d}, n);
    push(1, 1, p, {31'b0, b}, n);
  endtask

  task automatic idle();
    wa_en0 = 0; wb_en0 = 0; link_en0 = 0; iss_en0 = 0;
    wa_en1 = 0; wb_en1 = 0; link_en1 = 0; iss_en1 = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst0 = 1; rst1 = 1;
    rd_addr0 = '0; rd_addr1 = '0; dbg_addr0 = '0; dbg_addr1 = '0;
    wa_addr0 = '0; wb_addr0 = '0; iss_addr0 = '0;
    wa_data0 = '0; wb_data0 = '0; link_data0 = '0;
    wa_addr1 = '0; wb_addr1 = '0; iss_addr1 = '0;
    wa_data1 = '0; wb_data1 = '0; link_data1 = '0;
    step(); step();
    rst0 = 0; rst1 = 0;

    rd_addr0 = {5'd1, 5'd2};
    rd_addr1 = {4'd4, 4'd3, 4'd2, 4'd1};
    dbg_addr0 = 5'd9; dbg_addr1 = 4'd9;
    #1;
    checks++;
    if (rd_data0 !== '0 || rd_busy0 !== '0 || dbg_data0 !== '0 ||
        rd_data1 !== '0 || rd_busy1 !== '0 || dbg_data1 !== '0) begin
      failures++;
      $display("FAIL rst_direct d0=%h b0=%b g0=%h d1=%h b1=%b g1=%h",
               rd_data0, rd_busy0, dbg_data0, rd_data1, rd_busy1, dbg_data1);
    end
    rd_addr0 = '0; rd_addr1 = '0; dbg_addr0 = '0; dbg_addr1 = '0;

    rd0(0, 5'd3, 32'h0, 1'b0, "rst_init");
    step();

    // Basic writes, then reset drops a concurrent write
    idle();
    wa_en0 = 1; wa_addr0 = 5'd3; wa_data0 = 32'h11;
    wb_en0 = 1; wb_addr0 = 5'd4; wb_data0 = 32'h22;
    iss_en0 = 1; iss_addr0 = 5'd6;
    step();
    idle();
    rd0(0, 5'd3, 32'h11, 1'b0, "wr_a");
    rd0(1, 5'd4, 32'h22, 1'b0, "wr_b");
    step();
    idle();
    rd0(0, 5'd6, 32'h0, 1'b1, "iss_r6");
    rst0 = 1;
    wa_en0 = 1; wa_addr0 = 5'd5; wa_data0 = 32'h99;
    iss_en0 = 1; iss_addr0 = 5'd8;
    step();
    idle();
    rst0 = 0;
    for (int a = 0; a < 32; a++) begin
      rd0(0, 5'(a), 32'h0, 1'b0, "rst_all0");
      rd0(1, 5'(a), 32'h0, 1'b0, "rst_all1");
      dbg0(5'(a), 32'h0, "rst_dbg");
      step();
    end

    // wb beats wa on the same address; r0 stays zero
    idle();
    wa_en0 = 1; wa_addr0 = 5'd5; wa_data0 = 32'h1234;
    wb_en0 = 1; wb_addr0 = 5'd5; wb_data0 = 32'hBEEF;
    step();
    idle();
    rd0(0, 5'd5, 32'hBEEF, 1'b0, "wbwa_pri");
    dbg0(5'd5, 32'hBEEF, "wbwa_dbg");
    wa_en0 = 1; wa_addr0 = 5'd0; wa_data0 = 32'hFFFF;
    step();
    idle();
    rd0(0, 5'd0, 32'h0, 1'b0, "r0_zero");
    dbg0(5'd0, 32'h0, "r0_dbg");
    step();

    // Link write loses to wa, wins alone, does not clear pending
    idle();
    link_en0 = 1; link_data0 = 32'h400;
    wa_en0 = 1; wa_addr0 = 5'd31; wa_data0 = 32'h8;
    step();
    idle();
    rd0(0, 5'd31, 32'h8, 1'b0, "link_lose");
    step();
    idle();
    link_en0 = 1; link_data0 = 32'h400;
    step();
    idle();
    rd0(0, 5'd31, 32'h400, 1'b0, "link_win");
    step();
    idle();
    iss_en0 = 1; iss_addr0 = 5'd31;
    step();
    idle();
    link_en0 = 1; link_data0 = 32'h500;
    step();
    idle();
    rd0(0, 5'd31, 32'h500, 1'b1, "link_noclr");
    step();
    idle();
    wa_en0 = 1; wa_addr0 = 5'd31; wa_data0 = 32'hA;
    wb_en0 = 1; wb_addr0 = 5'd31; wb_data0 = 32'hB;
    link_en0 = 1; link_data0 = 32'hC;
    step();
    idle();
    rd0(0, 5'd31, 32'hB, 1'b0, "pri3");
    step();

    // Scoreboard set/clear
    idle();
    iss_en0 = 1; iss_addr0 = 5'd7;
    step();
    idle();
    rd0(1, 5'd7, 32'h0, 1'b1, "iss_busy");
    step();
    idle();
    wa_en0 = 1; wa_addr0 = 5'd7; wa_data0 = 32'h55;
    step();
    idle();
    rd0(1, 5'd7, 32'h55, 1'b0, "wa_clear");
    step();
    idle();
    iss_en0 = 1; iss_addr0 = 5'd7;
    wb_en0 = 1; wb_addr0 = 5'd7; wb_data0 = 32'h66;
    step();
    idle();
    rd0(1, 5'd7, 32'h66, 1'b1, "set_wins");
    iss_en0 = 1; iss_addr0 = 5'd0;
    step();
    idle();
    rd0(1, 5'd0, 32'h0, 1'b0, "iss_r0");
    step();

    // Read while writing the same register
    idle();
    wa_en0 = 1; wa_addr0 = 5'd9; wa_data0 = 32'h11;
    iss_en0 = 1; iss_addr0 = 5'd9;
    step();
    idle();
    wa_en0 = 1; wa_addr0 = 5'd9; wa_data0 = 32'hA5;
`ifdef RF_BYPASS_EN
    rd0(0, 5'd9, 32'hA5, 1'b0, "byp_same");
`else
    rd0(0, 5'd9, 32'h11, 1'b1, "byp_same");
`endif
    step();
    idle();
    rd0(0, 5'd9, 32'hA5, 1'b0, "byp_next");
    step();

    // Four-port 16-bit instance
    idle();
    wa_en1 = 1; wa_addr1 = 4'd1; wa_data1 = 16'h1111;
    wb_en1 = 1; wb_addr1 = 4'd2; wb_data1 = 16'h2222;
    step();
    idle();
    wa_en1 = 1; wa_addr1 = 4'd3; wa_data1 = 16'h3333;
    link_en1 = 1; link_data1 = 16'h4444;
    step();
    idle();
    rd1(0, 4'd1,  16'h1111, 1'b0, "p4_r1");
    rd1(1, 4'd2,  16'h2222, 1'b0, "p4_r2");
    rd1(2, 4'd3,  16'h3333, 1'b0, "p4_r3");
    rd1(3, 4'd15, 16'h4444, 1'b0, "p4_link");
    step();
    idle();
    wa_en1 = 1; wa_addr1 = 4'd5; wa_data1 = 16'hAAAA;
    iss_en1 = 1; iss_addr1 = 4'd6;
    step();
    idle();
    rd1(0, 4'd5, 16'hAAAA, 1'b0, "p4_r5");
    rd1(1, 4'd6, 16'h0,    1'b1, "p4_busy6");
    rd1(2, 4'd3, 16'h3333, 1'b0, "p4_r3b");
    rd1(3, 4'd15, 16'h4444, 1'b0, "p4_linkb");
    rst1 = 1;
    wa_en1 = 1; wa_addr1 = 4'd6; wa_data1 = 16'hBBBB;
    iss_en1 = 1; iss_addr1 = 4'd7;
    step();
    idle();
    rst1 = 0;
    rd1(0, 4'd1, 16'h0, 1'b0, "p4_rst_r1");
    rd1(1, 4'd5, 16'h0, 1'b0, "p4_rst_r5");
    rd1(2, 4'd6, 16'h0, 1'b0, "p4_rst_drop");
    rd1(3, 4'd7, 16'h0, 1'b0, "p4_rst_iss");
    dbg_addr1 = 4'd3;
    push(1, 2, 0, 32'h0, "p4_rst_dbg");
    step();

    step();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
